gray_rd_arbiter: RTL and testbench
==================================

GRAY_RD_ARBITER -- requirements
Module: gray_rd_arbiter

Interface
REQ-001 Parameter: BURST_MAX, 9, maximum accepted reads per grant before forced release (range 1..15).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rq0_req, rq1_req  input  1 each  read request from requester 0/1, held until accepted.
REQ-005 rq0_addr, rq1_addr  input  14 each  read address {row[6:0],col[6:0]} from requester 0/1.
REQ-006 rq0_last, rq1_last  input  1 each  marks the final read of the requester's burst.
REQ-007 rq0_gnt, rq1_gnt  output  1 each  request accepted this cycle.
REQ-008 rq0_rvalid, rq1_rvalid  output  1 each  read data valid for requester 0/1.
REQ-009 rq_rdata  output  8  shared read data bus, qualified by rqN_rvalid.
REQ-010 gray_ready  input  1  gray memory available.
REQ-011 gray_req  output  1  memory read strobe.
REQ-012 gray_addr  output  14  memory read address.
REQ-013 gray_data  input  8  memory data, valid the cycle after gray_req is high.

Function
REQ-014 The FSM SHALL have states IDLE, OWN0 and OWN1; OWN0/OWN1 mean the memory port belongs to requester 0/1.
REQ-015 IDLE -> OWNn SHALL occur when gray_ready=1 and any rqN_req=1; with both requesting, the one not flagged by the 1-bit priority pointer wins (pointer=0 after reset, so rq0 wins).
REQ-016 rqN_gnt SHALL be combinational: state==OWNn AND rqN_req AND gray_ready; a read is accepted at the edge where rqN_gnt=1.
REQ-017 On an accepted read, gray_req SHALL be 1 and gray_addr SHALL equal the accepted address in the following cycle; otherwise gray_req=0 and gray_addr holds.
REQ-018 rqN_rvalid SHALL be 1 exactly two cycles after acceptance (one cycle after gray_req), with rq_rdata=gray_data in that cycle; a registered tag routes the data to the issuing requester.
REQ-019 Total latency from acceptance to rvalid SHALL be 2 cycles; back-to-back accepts SHALL sustain one read per cycle.
REQ-020 OWNn -> IDLE SHALL occur on acceptance with rqN_last=1, on the BURST_MAX-th acceptance, or when rqN_req=0 while in OWNn; the pointer SHALL then flag requester n.
REQ-021 The burst counter (4 bits) SHALL clear on every entry to OWNn and increment per acceptance.
REQ-022 gray_ready=0 in OWNn SHALL hold state, pointer and burst count, block grants; in-flight reads still complete.
REQ-023 gray_ready=0 in IDLE SHALL block any transition.
REQ-024 Leaving OWNn while a read is in flight SHALL still deliver that read's rvalid to requester n.
REQ-025 A requester SHALL never receive rvalid for data it did not request; rq0_rvalid and rq1_rvalid SHALL never both be 1.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, pointer=0, burst count=0, tag pipeline cleared, gray_req=0, gray_addr=0, rq0_rvalid=rq1_rvalid=0, rq_rdata=0.
REQ-027 Reset asserted mid-burst SHALL discard in-flight reads with no later rvalid.

Configuration
REQ-028 Macro ARB_PERF_CNT_EN: when defined, outputs rq0_cnt and rq1_cnt (16 bits each, saturating at 16'hFFFF, reset to 0) SHALL count accepted reads per requester.
REQ-029 Without ARB_PERF_CNT_EN these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Single requester: rq0 issues 9 reads at 0x0081..0x0089, last on the 9th -> gray_addr 0x0081..0x0089 on consecutive cycles, 9 rq0_rvalid pulses at acceptance+2, return to IDLE.
REQ-031 Contention: both request from reset -> rq0 owns first burst of 9, then rq1; next contention grants rq1 after rq0 again.
REQ-032 Burst limit: rq1 requests 20 reads, never asserting last -> release after 9 accepts, re-grant after one IDLE cycle.
REQ-033 Stall: gray_ready dropped for 3 cycles after 4th accept of rq0 -> no gnt during stall, 4th read still returns, burst count resumes at 4.
REQ-034 Reset mid-burst with 2 reads in flight -> outputs 0 within the reset cycle, no rvalid afterwards.
REQ-035 With ARB_PERF_CNT_EN: 9 rq0 reads and 9 rq1 reads -> rq0_cnt=9, rq1_cnt=9.

Source files
------------

// File: rtl/gray_rd_arbiter.sv
// Two-requester read arbiter for a shared gray-code memory port with a 2-cycle read pipeline.
// Optional per-requester accept counters are enabled with `define ARB_PERF_CNT_EN.
module gray_rd_arbiter #(
  parameter int unsigned BURST_MAX = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rq0_req,
  input  logic        rq1_req,
  input  logic [13:0] rq0_addr,
  input  logic [13:0] rq1_addr,
  input  logic        rq0_last,
  input  logic        rq1_last,
  output logic        rq0_gnt,
  output logic        rq1_gnt,
  output logic        rq0_rvalid,
  output logic        rq1_rvalid,
  output logic [7:0]  rq_rdata,
  input  logic        gray_ready,
  output logic        gray_req,
  output logic [13:0] gray_addr,
  input  logic [7:0]  gray_data
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0] rq0_cnt,
  output logic [15:0] rq1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  state_t      state, state_nx;
  logic        ptr, ptr_nx;
  logic [3:0]  burst, burst_nx;
  logic        accept, acc_tag, acc_last, own_req;
  logic [13:0] acc_addr;
  logic        v1, t1, v2, t2;

  always_comb begin
    rq0_gnt  = (state == OWN0) && rq0_req && gray_ready;
    rq1_gnt  = (state == OWN1) && rq1_req && gray_ready;
    accept   = rq0_gnt | rq1_gnt;
    acc_tag  = rq1_gnt;
    acc_addr = rq1_gnt ? rq1_addr : rq0_addr;
    acc_last = rq1_gnt ? rq1_last : rq0_last;
    own_req  = (state == OWN1) ? rq1_req : rq0_req;
  end

  // ptr=1 flags requester 0 as most recent owner, so rq1 wins the next tie
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    burst_nx = burst;
    unique case (state)
      IDLE: begin
        if (gray_ready && (rq0_req || rq1_req)) begin
          burst_nx = '0;
          if (rq0_req && (!rq1_req || !ptr)) state_nx = OWN0;
          else                               state_nx = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (gray_ready) begin
          if (accept) burst_nx = burst + 4'd1;
          if (!own_req || acc_last || (burst == BURST_LAST)) begin
            state_nx = IDLE;
            ptr_nx   = (state == OWN0);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      burst     <= '0;
      v1        <= 1'b0;
      t1        <= 1'b0;
      v2        <= 1'b0;
      t2        <= 1'b0;
      gray_addr <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      burst <= burst_nx;
      v1    <= accept;
      t1    <= acc_tag;
      v2    <= v1;
      t2    <= t1;
      if (accept) gray_addr <= acc_addr;
    end
  end

  // Read data is only valid in the returning cycle, so it is steered, not registered
  assign gray_req   = v1;
  assign rq0_rvalid = v2 & ~t2;
  assign rq1_rvalid = v2 & t2;
  assign rq_rdata   = v2 ? gray_data : '0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq0_cnt <= '0;
      rq1_cnt <= '0;
    end else begin
      if (rq0_gnt && (rq0_cnt != '1)) rq0_cnt <= rq0_cnt + 16'd1;
      if (rq1_gnt && (rq1_cnt != '1)) rq1_cnt <= rq1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Scoreboard bench for gray_rd_arbiter: random requesters and memory model, behavioural arbitration model.
module tb_gray_rd_arbiter;
  localparam int BURST_MAX = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_d[2] = '{1'b0, 1'b0};
  logic [13:0] addr_d[2] = '{14'h0, 14'h0};
  logic        last_d[2] = '{1'b0, 1'b0};
  logic        rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid;
  logic [7:0]  rq_rdata;
  logic        gray_ready = 1'b1;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data = 8'h00;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] rq0_cnt, rq1_cnt;
  int          m_cnt[2] = '{0, 0};
`endif

  gray_rd_arbiter #(.BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .rq0_req(req_d[0]), .rq1_req(req_d[1]),
    .rq0_addr(addr_d[0]), .rq1_addr(addr_d[1]),
    .rq0_last(last_d[0]), .rq1_last(last_d[1]),
    .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt),
    .rq0_rvalid(rq0_rvalid), .rq1_rvalid(rq1_rvalid),
    .rq_rdata(rq_rdata),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data)
`ifdef ARB_PERF_CNT_EN
    , .rq0_cnt(rq0_cnt), .rq1_cnt(rq1_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] addr; logic last; int gap; } item_t;
  typedef struct { int who; logic [7:0] data; int due; } exp_t;

  item_t q0[$], q1[$];
  exp_t  sb[$];
  int checks = 0, passed = 0, cyc = 0;
  int acc[2] = '{0, 0};
  int ready_mode = 0;
  bit force_low = 1'b0;

  function automatic logic [7:0] mem(input logic [13:0] a);
    return a[13:6] ^ a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int qsize(input int n);
    return (n == 0) ? q0.size() : q1.size();
  endfunction

  function automatic item_t head(input int n);
    return (n == 0) ? q0[0] : q1[0];
  endfunction

  task automatic drive(input int n);
    item_t it;
    forever begin
      @(posedge clk); #1;
      if (!reset || qsize(n) == 0) req_d[n] = 1'b0;
      else begin
        it = head(n);
        if (it.gap > 0) begin
          req_d[n] = 1'b0;
          if (n == 0) q0[0].gap = q0[0].gap - 1; else q1[0].gap = q1[0].gap - 1;
        end else begin
          req_d[n] = 1'b1; addr_d[n] = it.addr; last_d[n] = it.last;
        end
      end
      @(negedge clk);
      if (reset && req_d[n] && ((n == 0) ? rq0_gnt : rq1_gnt) && qsize(n) > 0) begin
        if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        acc[n]++;
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      if (force_low) gray_ready = 1'b0;
      else if (ready_mode == 1) gray_ready = ($urandom_range(0, 4) != 0);
      else gray_ready = 1'b1;
    end
  end

  initial begin : memory
    logic sreq; logic [13:0] saddr;
    forever begin
      @(negedge clk); sreq = gray_req; saddr = gray_addr;
      @(posedge clk); #1;
      gray_data = sreq ? mem(saddr) : 8'($urandom);
    end
  end

  // Reference model: owner (-1 = nobody), reads in current grant, preferred requester on a tie
  initial begin : monitor
    int m_owner, m_burst, m_pref, o;
    bit acc_now, exp_rv, exp_greq;
    logic [13:0] exp_gaddr;
    exp_t e;
    m_owner = -1; m_burst = 0; m_pref = 0; exp_greq = 0; exp_gaddr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        m_owner = -1; m_burst = 0; m_pref = 0; exp_greq = 0; sb.delete();
`ifdef ARB_PERF_CNT_EN
        m_cnt[0] = 0; m_cnt[1] = 0;
`endif
        continue;
      end
      exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
      chk("rvalid_excl", 32'(rq0_rvalid & rq1_rvalid), 32'd0);
      chk("rvalid", 32'(rq0_rvalid | rq1_rvalid), 32'(exp_rv));
      if (exp_rv) begin
        e = sb.pop_front();
        if (rq0_rvalid | rq1_rvalid) begin
          chk("rvalid_who", 32'(rq1_rvalid), 32'(e.who));
          chk("rdata", 32'(rq_rdata), 32'(e.data));
        end
      end
      chk("gray_req", 32'(gray_req), 32'(exp_greq));
      if (exp_greq) chk("gray_addr", 32'(gray_addr), 32'(exp_gaddr));
`ifdef ARB_PERF_CNT_EN
      chk("cnt0", 32'(rq0_cnt), 32'(m_cnt[0]));
      chk("cnt1", 32'(rq1_cnt), 32'(m_cnt[1]));
`endif
      o = m_owner;
      acc_now = (o >= 0) && gray_ready && req_d[o];
      chk("gnt0", 32'(rq0_gnt), 32'(acc_now && o == 0));
      chk("gnt1", 32'(rq1_gnt), 32'(acc_now && o == 1));
      exp_greq = acc_now;
      if (acc_now) begin
        exp_gaddr = addr_d[o];
        sb.push_back('{o, mem(addr_d[o]), cyc + 2});
`ifdef ARB_PERF_CNT_EN
        if (m_cnt[o] < 65535) m_cnt[o]++;
`endif
      end
      if (o < 0) begin
        if (gray_ready && (req_d[0] || req_d[1])) begin
          m_owner = (req_d[0] && req_d[1]) ? m_pref : (req_d[0] ? 0 : 1);
          m_burst = 0;
        end
      end else if (gray_ready) begin
        if (acc_now) m_burst++;
        if (!acc_now || last_d[o] || m_burst == BURST_MAX) begin
          m_pref = 1 - o; m_owner = -1;
        end
      end
    end
  end

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < limit) begin
      @(posedge clk); n++;
    end
    chk("drain_in_time", 32'(n < limit), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_acc(input int n, input int target);
    int k = 0;
    while (acc[n] < target && k < 200) begin
      @(negedge clk); #1; k++;
    end
    chk("acc_in_time", 32'(acc[n] >= target), 32'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_gray_req", 32'(gray_req), 32'd0);
    chk("rst_gray_addr", 32'(gray_addr), 32'd0);
    chk("rst_rvalid0", 32'(rq0_rvalid), 32'd0);
    chk("rst_rvalid1", 32'(rq1_rvalid), 32'd0);
    chk("rst_rdata", 32'(rq_rdata), 32'd0);
  endtask

  initial begin : global_timeout
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base;
    #12;
    check_reset_outputs();
    @(posedge clk); #3 reset = 1'b1;

    // Contention from reset: rq0 first, then rq1, then rq0 again
    for (int i = 0; i < 12; i++) begin
      q0.push_back('{14'($urandom), 1'b0, 0});
      q1.push_back('{14'($urandom), 1'b0, 0});
    end
    wait_drain(300);

    // Single requester, 9 reads with last on the 9th
    for (int i = 0; i < 9; i++) q0.push_back('{14'h0081 + 14'(i), (i == 8), 0});
    wait_drain(100);

    // rq1 never asserts last: released by the burst limit
    for (int i = 0; i < 20; i++) q1.push_back('{14'($urandom), 1'b0, 0});
    wait_drain(200);

    // Stall after the 4th accept of rq0
    base = acc[0];
    for (int i = 0; i < 12; i++) q0.push_back('{14'($urandom), 1'b0, 0});
    wait_acc(0, base + 4);
    force_low = 1'b1;
    repeat (3) @(posedge clk);
    #2 force_low = 1'b0;
    wait_drain(200);

    // Random traffic with gaps, random last and random memory readiness
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      q0.push_back('{14'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0});
      q1.push_back('{14'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0});
    end
    wait_drain(5000);
    ready_mode = 0;

    // Reset with two reads in flight
    base = acc[0];
    for (int i = 0; i < 10; i++) q0.push_back('{14'($urandom), 1'b0, 0});
    wait_acc(0, base + 2);
    @(posedge clk); #3;
    chk("pre_rst_rvalid0", 32'(rq0_rvalid), 32'd1);
    chk("pre_rst_gray_req", 32'(gray_req), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (10) @(posedge clk);

    // Short burst after reset, plus a second contention round
    for (int i = 0; i < 5; i++) begin
      q0.push_back('{14'($urandom), (i == 4), 0});
      q1.push_back('{14'($urandom), (i == 4), 0});
    end
    wait_drain(200);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
